// File: rtl/game_timer_ctrl.sv
// rtl/game_timer_ctrl.sv - game run controller: state sequencing, one-second tick, score and high score
module game_timer_ctrl #(
    parameter int          TICK_DIV  = 100000000,
    parameter int          PENALTY   = 65,
    parameter logic [15:0] MAX_SCORE = 16'hFFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        pause,
    input  logic        goal,
    input  logic        gameover,
    output logic [1:0]  state,
    output logic        tick,
    output logic [15:0] seconds,
    output logic [15:0] score,
    output logic [15:0] high_score,
    output logic        win,
    output logic        new_high
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_PAUSE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam int            PW       = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
    localparam logic [15:0]   PEN      = 16'(PENALTY);

    logic [1:0]    state_q, state_d;
    logic [PW-1:0] pres_q, pres_d;
    logic [15:0]   seconds_q, seconds_d;
    logic [15:0]   score_q, score_d;
    logic [15:0]   high_q, high_d;
    logic          win_q, win_d;
    logic          new_high_q, new_high_d;
    logic          tick_q, tick_d;
    logic          start_prev_q, pause_prev_q;
    logic          start_edge_q, start_edge_d;
    logic          pause_edge_q, pause_edge_d;

    // Edges are registered, so button actions land one edge after they are sampled.
    assign start_edge_d = start & ~start_prev_q;
    assign pause_edge_d = pause & ~pause_prev_q;

    always_comb begin
        state_d    = state_q;
        pres_d     = pres_q;
        seconds_d  = seconds_q;
        score_d    = score_q;
        high_d     = high_q;
        win_d      = win_q;
        new_high_d = 1'b0;
        tick_d     = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_edge_q) begin
                    state_d   = S_RUN;
                    pres_d    = '0;
                    seconds_d = '0;
                    score_d   = MAX_SCORE;
                    win_d     = 1'b0;
                end
            end
            S_RUN: begin
                if (goal) begin
                    state_d = S_DONE;
                    win_d   = 1'b1;
                    if (score_q > high_q) begin
                        high_d     = score_q;
                        new_high_d = 1'b1;
                    end
                end else if (gameover) begin
                    state_d = S_DONE;
                    win_d   = 1'b0;
                end else begin
                    if (pres_q == PRE_LAST) begin
                        pres_d    = '0;
                        tick_d    = 1'b1;
                        seconds_d = seconds_q + 16'd1;
                        if (score_q <= PEN) begin
                            score_d = '0;
                            state_d = S_DONE;
                            win_d   = 1'b0;
                        end else begin
                            score_d = score_q - PEN;
                        end
                    end else begin
                        pres_d = pres_q + PW'(1);
                    end
                    // A pause edge coinciding with a tick still lets the tick count.
                    if (pause_edge_q && state_d == S_RUN) begin
                        state_d = S_PAUSE;
                    end
                end
            end
            S_PAUSE: begin
                if (gameover) begin
                    state_d = S_DONE;
                    win_d   = 1'b0;
                end else if (pause_edge_q) begin
                    state_d = S_RUN;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            pres_q       <= '0;
            seconds_q    <= '0;
            score_q      <= '0;
            high_q       <= '0;
            win_q        <= 1'b0;
            new_high_q   <= 1'b0;
            tick_q       <= 1'b0;
            start_prev_q <= 1'b1;
            pause_prev_q <= 1'b1;
            start_edge_q <= 1'b0;
            pause_edge_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pres_q       <= pres_d;
            seconds_q    <= seconds_d;
            score_q      <= score_d;
            high_q       <= high_d;
            win_q        <= win_d;
            new_high_q   <= new_high_d;
            tick_q       <= tick_d;
            start_prev_q <= start;
            pause_prev_q <= pause;
            start_edge_q <= start_edge_d;
            pause_edge_q <= pause_edge_d;
        end
    end

    assign state      = state_q;
    assign tick       = tick_q;
    assign seconds    = seconds_q;
    assign score      = score_q;
    assign high_score = high_q;
    assign win        = win_q;
    assign new_high   = new_high_q;
endmodule
